// File: rtl/ooo_prf_multiport_if.sv
// Bus bundle for the multiported physical register file: read, writeback and
// rename-allocation ports plus the registered writeback-conflict flag.
interface ooo_prf_multiport_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PREGS  = 64,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int NUM_ALLOC  = 2
);
    localparam int PREG_W = $clog2(NUM_PREGS);

    logic [NUM_RD-1:0]               rd_en;
    logic [NUM_RD*PREG_W-1:0]        rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0]    rd_data;
    logic [NUM_RD-1:0]               rd_ready;
    logic [NUM_WR-1:0]               wr_en;
    logic [NUM_WR*PREG_W-1:0]        wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0]    wr_data;
    logic [NUM_ALLOC-1:0]            alloc_en;
    logic [NUM_ALLOC*PREG_W-1:0]     alloc_addr;
    logic                            wr_conflict;

    // Issue/rename/writeback logic drives the requests; the register file answers.
    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_ready, wr_conflict
    );
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_ready, wr_conflict
    );
endinterface

// File: rtl/ooo_prf_multiport.sv
// Physical register file with per-entry ready bits, NUM_WR writeback ports bypassed
// into NUM_RD combinational read ports, and NUM_ALLOC ready-clearing rename ports.
module ooo_prf_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PREGS  = 64,
    parameter int NUM_RD     = 4,
    parameter int NUM_WR     = 2,
    parameter int NUM_ALLOC  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ooo_prf_multiport_if.slave    bus
);
    localparam int PREG_W = $clog2(NUM_PREGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_PREGS];
    logic [NUM_PREGS-1:0]  r_ready;
    logic                  r_conflict;

    logic [PREG_W-1:0]     w_wr_addr    [NUM_WR];
    logic [DATA_WIDTH-1:0] w_wr_data    [NUM_WR];
    logic [PREG_W-1:0]     w_alloc_addr [NUM_ALLOC];
    logic [NUM_WR-1:0]     w_wr_live;
    logic                  w_conflict;
    logic [NUM_RD*DATA_WIDTH-1:0] w_rd_data;
    logic [NUM_RD-1:0]     w_rd_ready;

    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            w_wr_addr[j] = bus.wr_addr[j*PREG_W +: PREG_W];
            w_wr_data[j] = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
            w_wr_live[j] = bus.wr_en[j] && (w_wr_addr[j] != '0);
        end
        for (int k = 0; k < NUM_ALLOC; k++) begin
            w_alloc_addr[k] = bus.alloc_addr[k*PREG_W +: PREG_W];
        end
    end

    // Preg 0 is excluded through w_wr_live, so it never counts as a conflict.
    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int l = j + 1; l < NUM_WR; l++) begin
                if (w_wr_live[j] && w_wr_live[l] && (w_wr_addr[j] == w_wr_addr[l])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_data  = '0;
        w_rd_ready = '1;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [PREG_W-1:0] w_a;
            logic              w_hit;
            w_a   = bus.rd_addr[i*PREG_W +: PREG_W];
            w_hit = 1'b0;
            if (bus.rd_en[i] && (w_a != '0)) begin
                // Ascending scan so the highest-numbered matching writeback wins.
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wr_live[j] && (w_wr_addr[j] == w_a)) begin
                        w_hit = 1'b1;
                        w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_wr_data[j];
                    end
                end
                if (!w_hit) begin
                    w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_a];
                    w_rd_ready[i] = r_ready[w_a];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PREGS; p++) begin
                r_regs[p] <= '0;
            end
            r_ready    <= '1;
            r_conflict <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_live[j]) begin
                    r_regs[w_wr_addr[j]]  <= w_wr_data[j];
                    r_ready[w_wr_addr[j]] <= 1'b1;
                end
            end
            // Allocs come after writes: a new producer overrides a same-cycle writeback.
            for (int k = 0; k < NUM_ALLOC; k++) begin
                if (bus.alloc_en[k] && (w_alloc_addr[k] != '0)) begin
                    r_ready[w_alloc_addr[k]] <= 1'b0;
                end
            end
            r_conflict <= w_conflict;
        end
    end

    assign bus.rd_data     = w_rd_data;
    assign bus.rd_ready    = w_rd_ready;
    assign bus.wr_conflict = r_conflict;
endmodule

// File: tb/tb_ooo_prf_multiport.sv
// Self-checking bench for ooo_prf_multiport: directed scenarios plus random traffic
// compared against an array-based model of the register file.
module tb_ooo_prf_multiport;
    localparam int DW = 32;
    localparam int NP = 64;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam int NA = 2;
    localparam int PW = $clog2(NP);

    logic clk;
    logic rst_n;

    ooo_prf_multiport_if #(.DATA_WIDTH(DW), .NUM_PREGS(NP), .NUM_RD(NR),
                           .NUM_WR(NW), .NUM_ALLOC(NA)) if_bus ();

    ooo_prf_multiport #(.DATA_WIDTH(DW), .NUM_PREGS(NP), .NUM_RD(NR),
                        .NUM_WR(NW), .NUM_ALLOC(NA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] m_mem [NP];
    logic          m_rdy [NP];
    logic          m_conflict;
    logic [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_mem[p] = '0;
            m_rdy[p] = 1'b1;
        end
        m_conflict = 1'b0;
    endtask

    function automatic void model_read(input logic en, input logic [PW-1:0] a,
                                       output logic [DW-1:0] d, output logic r);
        logic hit;
        d = '0;
        r = 1'b1;
        hit = 1'b0;
        if (!en || a == 0) return;
        for (int j = 0; j < NW; j++) begin
            if (if_bus.wr_en[j] && if_bus.wr_addr[j*PW +: PW] == a) begin
                hit = 1'b1;
                d = if_bus.wr_data[j*DW +: DW];
            end
        end
        if (!hit) begin
            d = m_mem[a];
            r = m_rdy[a];
        end
    endfunction

    // Applies the current inputs to the model as a clock edge would.
    task automatic model_edge();
        int cnt [NP];
        logic next_conflict;
        next_conflict = 1'b0;
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        for (int j = 0; j < NW; j++) begin
            int a;
            a = int'(if_bus.wr_addr[j*PW +: PW]);
            if (if_bus.wr_en[j] && a != 0) begin
                cnt[a]++;
                if (cnt[a] > 1) next_conflict = 1'b1;
                m_mem[a] = if_bus.wr_data[j*DW +: DW];
                m_rdy[a] = 1'b1;
            end
        end
        for (int k = 0; k < NA; k++) begin
            int a;
            a = int'(if_bus.alloc_addr[k*PW +: PW]);
            if (if_bus.alloc_en[k] && a != 0) m_rdy[a] = 1'b0;
        end
        m_conflict = next_conflict;
    endtask

    task automatic compare(input string tag);
        logic [DW-1:0] d;
        logic r;
        logic [NR-1:0] exp_rdy;
        for (int i = 0; i < NR; i++) begin
            model_read(if_bus.rd_en[i], if_bus.rd_addr[i*PW +: PW], d, r);
            exp_q.push_back(d);
            exp_rdy[i] = r;
        end
        for (int i = 0; i < NR; i++) begin
            d = exp_q.pop_front();
            check($sformatf("%s_rd%0d_data", tag, i), 64'(if_bus.rd_data[i*DW +: DW]), 64'(d));
            check($sformatf("%s_rd%0d_ready", tag, i), 64'(if_bus.rd_ready[i]), 64'(exp_rdy[i]));
        end
        check($sformatf("%s_conflict", tag), 64'(if_bus.wr_conflict), 64'(m_conflict));
    endtask

    // Inputs are set after a falling edge; check mid-low-phase, then clock it in.
    task automatic cycle(input string tag);
        #2;
        compare(tag);
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_bus.rd_en = '0;      if_bus.rd_addr = '0;
        if_bus.wr_en = '0;      if_bus.wr_addr = '0;  if_bus.wr_data = '0;
        if_bus.alloc_en = '0;   if_bus.alloc_addr = '0;
    endtask

    task automatic set_rd(input int i, input int a);
        if_bus.rd_en[i] = 1'b1;
        if_bus.rd_addr[i*PW +: PW] = PW'(a);
    endtask

    task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
        if_bus.wr_en[j] = 1'b1;
        if_bus.wr_addr[j*PW +: PW] = PW'(a);
        if_bus.wr_data[j*DW +: DW] = d;
    endtask

    task automatic set_alloc(input int k, input int a);
        if_bus.alloc_en[k] = 1'b1;
        if_bus.alloc_addr[k*PW +: PW] = PW'(a);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state at pregs 0, 5, 63, 17
        set_rd(0, 0); set_rd(1, 5); set_rd(2, 63); set_rd(3, 17);
        #2;
        check("reset_rd_data", 64'(if_bus.rd_data), 64'(0));
        check("reset_rd_ready", 64'(if_bus.rd_ready), 64'(4'b1111));
        check("reset_conflict", 64'(if_bus.wr_conflict), 64'(0));
        cycle("reset");

        // Alloc clears ready next cycle; writeback bypasses then lands in storage
        clear_inputs(); set_rd(0, 5); set_alloc(0, 5);
        cycle("alloc5");
        clear_inputs(); set_rd(0, 5);
        #2;
        check("alloc5_notready", 64'(if_bus.rd_ready[0]), 64'(0));
        cycle("alloc5_read");
        clear_inputs(); set_rd(0, 5); set_wr(1, 5, 32'hDEADBEEF);
        #2;
        check("wb5_bypass", 64'(if_bus.rd_data[DW-1:0]), 64'hDEADBEEF);
        cycle("wb5");
        clear_inputs(); set_rd(0, 5);
        #2;
        check("wb5_stored", 64'(if_bus.rd_data[DW-1:0]), 64'hDEADBEEF);
        cycle("wb5_read");

        // Preg 0 ignores writes and allocs
        clear_inputs(); set_rd(0, 0); set_rd(1, 0); set_wr(0, 0, 32'h1234); set_alloc(1, 0);
        cycle("p0_wr");
        clear_inputs(); set_rd(0, 0);
        cycle("p0_after1");
        cycle("p0_after2");

        // Same-address writeback: port 1 wins, conflict pulses for one cycle
        clear_inputs(); set_rd(2, 9); set_wr(0, 9, 32'hAAAA); set_wr(1, 9, 32'h5555);
        #2;
        check("dup9_bypass", 64'(if_bus.rd_data[2*DW +: DW]), 64'h5555);
        cycle("dup9");
        clear_inputs(); set_rd(2, 9);
        #2;
        check("dup9_conflict_hi", 64'(if_bus.wr_conflict), 64'(1));
        check("dup9_stored", 64'(if_bus.rd_data[2*DW +: DW]), 64'h5555);
        cycle("dup9_next");
        #2;
        check("dup9_conflict_lo", 64'(if_bus.wr_conflict), 64'(0));
        cycle("dup9_next2");

        // Alloc and write to the same preg: data written, ready ends 0
        clear_inputs(); set_wr(0, 12, 32'h77); set_alloc(1, 12);
        cycle("aw12");
        clear_inputs(); set_rd(3, 12);
        #2;
        check("aw12_data", 64'(if_bus.rd_data[3*DW +: DW]), 64'h77);
        check("aw12_ready", 64'(if_bus.rd_ready[3]), 64'(0));
        cycle("aw12_read");

        // Random traffic on a narrow address window to provoke collisions
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 3) != 0) set_rd(i, $urandom_range(0, 15));
            for (int j = 0; j < NW; j++)
                if ($urandom_range(0, 1) != 0) set_wr(j, $urandom_range(0, 15), $urandom());
            for (int k = 0; k < NA; k++)
                if ($urandom_range(0, 2) == 0) set_alloc(k, $urandom_range(0, 15));
            cycle("rand");
        end

        // Reset asserted mid-cycle discards an in-flight write to preg 20
        clear_inputs(); set_rd(0, 9); set_rd(1, 5); set_wr(0, 20, 32'hCAFE0020);
        set_wr(1, 3, 32'h3); set_alloc(0, 7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare("mid_reset");
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        set_rd(0, 20); set_rd(1, 3); set_rd(2, 7); set_rd(3, 9);
        #2;
        check("post_reset_p20_data", 64'(if_bus.rd_data[DW-1:0]), 64'(0));
        check("post_reset_p20_ready", 64'(if_bus.rd_ready[0]), 64'(1));
        cycle("post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
